// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 frame receiver with start/data/parity/stop checking, error flags and an inter-edge timeout
module ps2_frame_rx #(
  parameter int DATA_W = 8,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rx_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              busy
);
  localparam int FRAME_W = DATA_W + 2 + PARITY_EN;
  localparam int CW = $clog2(FRAME_W + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] cs, ds;
  logic prev;
  logic [FRAME_W-1:0] sr;
  logic [CW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic cur, d, fall;
  assign cur = cs[SYNC_STAGES-1];
  assign d = ds[SYNC_STAGES-1];
  assign fall = prev & ~cur;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cs <= '1;
      ds <= '1;
      prev <= 1'b1;
      sr <= '0;
      bcnt <= '0;
      tcnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cs <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds <= {ds[SYNC_STAGES-2:0], ps2_data};
      prev <= cur;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (fall && rx_en && !d) begin
          state <= SHIFT;
          sr <= {d, sr[FRAME_W-1:1]};
          bcnt <= CW'(1);
          tcnt <= '0;
        end
        SHIFT: if (fall) begin
          sr <= {d, sr[FRAME_W-1:1]};
          bcnt <= bcnt + CW'(1);
          tcnt <= '0;
          state <= bcnt == CW'(FRAME_W - 1) ? CHECK : SHIFT;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          timeout_err <= 1'b1;
          sr <= '0;
          bcnt <= '0;
          tcnt <= '0;
          state <= IDLE;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        CHECK: begin
          dout <= sr[DATA_W:1];
          parity_err <= (PARITY_EN != 0) && ((^sr[DATA_W:1] ^ sr[DATA_W+1]) != (PARITY_ODD != 0));
          frame_err <= ~sr[FRAME_W-1];
          dout_valid <= 1'b1;
          sr <= '0;
          bcnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed scoreboard bench for ps2_frame_rx (default build and a 9-bit no-parity build)
module tb_ps2_frame_rx;
  typedef struct packed {
    logic to;
    logic [15:0] d;
    logic pe;
    logic fe;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pc0 = 1'b1, pd0 = 1'b1, pc1 = 1'b1, pd1 = 1'b1;
  logic en0 = 1'b1, en1 = 1'b1;
  logic [7:0] dout0;
  logic [8:0] dout1;
  logic dv0, pe0, fe0, to0, busy0;
  logic dv1, pe1, fe1, to1, busy1;
  logic busy_while_off = 1'b0;
  int cmp = 0;
  int err = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  always #5 clk = ~clk;
  ps2_frame_rx dut0 (
    .clk(clk), .rst(rst), .ps2_clk(pc0), .ps2_data(pd0), .rx_en(en0),
    .dout(dout0), .dout_valid(dv0), .parity_err(pe0), .frame_err(fe0),
    .timeout_err(to0), .busy(busy0)
  );
  ps2_frame_rx #(.DATA_W(9), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(pc1), .ps2_data(pd1), .rx_en(en1),
    .dout(dout1), .dout_valid(dv1), .parity_err(pe1), .frame_err(fe1),
    .timeout_err(to1), .busy(busy1)
  );
  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction
  function automatic logic [15:0] f8(input logic [7:0] d, input logic pf, input logic stop);
    return {5'b0, stop, ~^d ^ pf, d, 1'b0};
  endfunction
  function automatic exp_t ev(input logic to, input logic [15:0] d, input logic pe, input logic fe);
    return '{to: to, d: d, pe: pe, fe: fe};
  endfunction
  task automatic send(input bit w, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (w) pd1 = b[i]; else pd0 = b[i];
      repeat (5) @(posedge clk);
      #1;
      if (w) pc1 = 1'b0; else pc0 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      if (w) pc1 = 1'b1; else pc0 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
    if (w) pd1 = 1'b1; else pd0 = 1'b1;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    @(negedge clk);
    check(tag, q0.size() + q1.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!en1 && busy1) busy_while_off = 1'b1;
    if (!dv0 && (pe0 || fe0)) check("dut0_flags_idle", {pe0, fe0}, 0);
    if (!dv1 && (pe1 || fe1)) check("dut1_flags_idle", {pe1, fe1}, 0);
    if (dv0 || to0) begin
      if (q0.size() == 0) check("dut0_unexpected", {dv0, to0}, 0);
      else begin
        e0 = q0.pop_front();
        check("dut0_kind", {dv0, to0}, e0.to ? 2'b01 : 2'b10);
        check("dut0_dout", dout0, e0.d);
        check("dut0_perr", pe0, e0.pe);
        check("dut0_ferr", fe0, e0.fe);
      end
    end
    if (dv1 || to1) begin
      if (q1.size() == 0) check("dut1_unexpected", {dv1, to1}, 0);
      else begin
        e1 = q1.pop_front();
        check("dut1_kind", {dv1, to1}, e1.to ? 2'b01 : 2'b10);
        check("dut1_dout", dout1, e1.d);
        check("dut1_perr", pe1, e1.pe);
        check("dut1_ferr", fe1, e1.fe);
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout0, 0);
    check("rst_outs", {dv0, pe0, fe0, to0, busy0}, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    q0.push_back(ev(0, 16'h1C, 0, 0));
    send(0, f8(8'h1C, 0, 1), 11);
    drain("t1_drain");
    check("t1_hold", dout0, 8'h1C);
    q0.push_back(ev(0, 16'h1C, 1, 0));
    send(0, f8(8'h1C, 1, 1), 11);
    drain("t2_drain");
    q0.push_back(ev(0, 16'hF0, 0, 1));
    send(0, f8(8'hF0, 0, 0), 11);
    q0.push_back(ev(0, 16'h55, 0, 0));
    send(0, f8(8'h55, 0, 1), 11);
    drain("t3_drain");
    send(0, f8(8'hAA, 0, 1), 5);
    @(negedge clk);
    check("t4_busy_mid", busy0, 1);
    q0.push_back(ev(1, 16'h55, 0, 0));
    repeat (5010) @(posedge clk);
    drain("t4_timeout_drain");
    check("t4_busy_after", busy0, 0);
    check("t4_dout_kept", dout0, 8'h55);
    q0.push_back(ev(0, 16'hAA, 0, 0));
    send(0, f8(8'hAA, 0, 1), 11);
    drain("t4_drain");
    send(0, f8(8'h12, 0, 1), 6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy_after_rst", busy0, 0);
    check("t5_dout_after_rst", dout0, 0);
    q0.push_back(ev(0, 16'h12, 0, 0));
    send(0, f8(8'h12, 0, 1), 11);
    drain("t5_drain");
    check("t5_hold", dout0, 8'h12);
    q1.push_back(ev(0, 16'h1A5, 0, 0));
    send(1, {4'b0, 1'b1, 9'h1A5, 1'b0}, 11);
    drain("t6_drain");
    check("t6_hold", dout1, 9'h1A5);
    en1 = 1'b0;
    send(1, {4'b0, 1'b1, 9'h0F3, 1'b0}, 11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_busy_while_off", busy_while_off, 0);
    check("t6_dout_kept", dout1, 9'h1A5);
    en1 = 1'b1;
    drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
